// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris board engine.
// Holds the engine state enum, move encodings and index-width helper.
package tetris_pkg;

    typedef enum logic [2:0] {
        ST_SPAWN,
        ST_FALL,
        ST_LOCK,
        ST_CLEAR,
        ST_OVER
    } state_e;

    localparam logic [1:0] MOVE_NONE  = 2'b00;
    localparam logic [1:0] MOVE_LEFT  = 2'b01;
    localparam logic [1:0] MOVE_RIGHT = 2'b10;
    localparam logic [1:0] MOVE_DROP  = 2'b11;

    // Bits needed to index n rows or columns (at least one bit).
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tetris_gravity_timer.sv
// Modulo-DROP_DIV gravity counter for the Tetris board engine.
// step_o is high on the cycle the counter holds DROP_DIV-1.
module tetris_gravity_timer
    import tetris_pkg::*;
#(
    parameter int DROP_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic step_o
);

    localparam int CW = idx_bits(DROP_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign step_o = (cnt_q == CW'(DROP_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = step_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tetris_board_engine.sv
// Single-clock Tetris board engine: falling bar piece, locked stack,
// row clearing one scan step per cycle, line counting and game over.
module tetris_board_engine
    import tetris_pkg::*;
#(
    parameter int BOARD_W  = 4,
    parameter int BOARD_H  = 8,
    parameter int PIECE_W  = 2,
    parameter int DROP_DIV = 4,
    parameter int LINE_W   = 8
) (
    input  logic                       in_clk,
    input  logic                       in_restart,
    input  logic [1:0]                 in_move,
    output logic [BOARD_W*BOARD_H-1:0] board_out,
    output logic [LINE_W-1:0]          out_lines,
    output logic                       out_game_over,
    output logic                       out_busy
);

    localparam int N         = BOARD_W * BOARD_H;
    localparam int RW        = idx_bits(BOARD_H);
    localparam int CW        = idx_bits(BOARD_W);
    localparam int SPAWN_COL = (BOARD_W - PIECE_W) / 2;
    localparam logic [N-1:0] BAR = N'((64'd1 << PIECE_W) - 64'd1);

    state_e            state_q, state_d;
    logic [N-1:0]      stack_q, stack_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     scan_q, scan_d;
    logic              drop_q, drop_d;
    logic [LINE_W-1:0] lines_q, lines_d;

    logic         tmr_en;
    logic         tmr_clr;
    logic         tmr_step;
    logic         step;
    logic [N-1:0] cur_mask;
    logic [N-1:0] spawn_mask;
    logic [N-1:0] left_mask;
    logic [N-1:0] right_mask;
    logic [N-1:0] down_mask;
    logic [N-1:0] keep_mask;
    logic [N-1:0] cleared;
    logic         row_full;

    function automatic logic [N-1:0] bar_at(input int row, input int col);
        return BAR << (row * BOARD_W + col);
    endfunction

    tetris_gravity_timer #(
        .DROP_DIV(DROP_DIV)
    ) u_timer (
        .clk_i (in_clk),
        .rst_i (in_restart),
        .en_i  (tmr_en),
        .clr_i (tmr_clr),
        .step_o(tmr_step)
    );

    assign tmr_en     = (state_q == ST_FALL);
    assign step       = drop_q | tmr_step;
    assign cur_mask   = bar_at(int'(row_q), int'(col_q));
    assign spawn_mask = bar_at(0, SPAWN_COL);
    assign left_mask  = bar_at(int'(row_q), int'(col_q) - 1);
    assign right_mask = bar_at(int'(row_q), int'(col_q) + 1);
    assign down_mask  = bar_at(int'(row_q) + 1, int'(col_q));

    // Rows at or above the scan row move down one; rows below stay put.
    assign row_full  = &stack_q[int'(scan_q)*BOARD_W +: BOARD_W];
    assign keep_mask = {N{1'b1}} << ((int'(scan_q) + 1) * BOARD_W);
    assign cleared   = (stack_q & keep_mask)
                     | ((stack_q << BOARD_W) & ~keep_mask);

    always_comb begin
        state_d = state_q;
        stack_d = stack_q;
        row_d   = row_q;
        col_d   = col_q;
        scan_d  = scan_q;
        drop_d  = drop_q;
        lines_d = lines_q;
        tmr_clr = 1'b0;
        unique case (state_q)
            ST_SPAWN: begin
                row_d   = '0;
                col_d   = CW'(SPAWN_COL);
                drop_d  = 1'b0;
                tmr_clr = 1'b1;
                state_d = (|(spawn_mask & stack_q)) ? ST_OVER : ST_FALL;
            end
            ST_FALL: begin
                if (!drop_q && in_move == MOVE_DROP) begin
                    drop_d = 1'b1;
                end
                if (!step && !drop_q) begin
                    if (in_move == MOVE_LEFT && col_q != '0
                        && !(|(left_mask & stack_q))) begin
                        col_d = col_q - CW'(1);
                    end
                    if (in_move == MOVE_RIGHT
                        && col_q != CW'(BOARD_W - PIECE_W)
                        && !(|(right_mask & stack_q))) begin
                        col_d = col_q + CW'(1);
                    end
                end
                if (step) begin
                    if (row_q != RW'(BOARD_H - 1)
                        && !(|(down_mask & stack_q))) begin
                        row_d = row_q + RW'(1);
                    end else begin
                        state_d = ST_LOCK;
                    end
                end
            end
            ST_LOCK: begin
                stack_d = stack_q | cur_mask;
                scan_d  = RW'(BOARD_H - 1);
                state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (row_full) begin
                    stack_d = cleared;
                    if (lines_q != '1) begin
                        lines_d = lines_q + LINE_W'(1);
                    end
                end else if (scan_q == '0) begin
                    state_d = ST_SPAWN;
                end else begin
                    scan_d = scan_q - RW'(1);
                end
            end
            ST_OVER: begin
                state_d = ST_OVER;
            end
            default: begin
                state_d = ST_SPAWN;
            end
        endcase
    end

    always_ff @(posedge in_clk or posedge in_restart) begin
        if (in_restart) begin
            state_q <= ST_SPAWN;
            stack_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            scan_q  <= '0;
            drop_q  <= 1'b0;
            lines_q <= '0;
        end else begin
            state_q <= state_d;
            stack_q <= stack_d;
            row_q   <= row_d;
            col_q   <= col_d;
            scan_q  <= scan_d;
            drop_q  <= drop_d;
            lines_q <= lines_d;
        end
    end

    assign board_out     = stack_q | ((state_q == ST_FALL) ? cur_mask : '0);
    assign out_lines     = lines_q;
    assign out_game_over = (state_q == ST_OVER);
    assign out_busy      = (state_q == ST_LOCK) || (state_q == ST_CLEAR);

endmodule

// File: tb/tb_tetris_board_engine.sv
// Self-checking bench for tetris_board_engine against a grid-based
// reference model of the game rules.
module tb_tetris_board_engine;

    localparam int W  = 4;
    localparam int H  = 8;
    localparam int PW = 2;
    localparam int DD = 4;
    localparam int LW = 8;
    localparam int N  = W * H;

    localparam logic [1:0] MV_NONE  = 2'b00;
    localparam logic [1:0] MV_LEFT  = 2'b01;
    localparam logic [1:0] MV_RIGHT = 2'b10;
    localparam logic [1:0] MV_DROP  = 2'b11;

    localparam int M_SPAWN = 0;
    localparam int M_FALL  = 1;
    localparam int M_LOCK  = 2;
    localparam int M_CLEAR = 3;
    localparam int M_OVER  = 4;

    logic          in_clk = 1'b0;
    logic          in_restart;
    logic [1:0]    in_move;
    logic [N-1:0]  board_out;
    logic [LW-1:0] out_lines;
    logic          out_game_over;
    logic          out_busy;

    int total = 0;
    int bad   = 0;

    bit stk[H][W];
    int pr, pc, mst, mcnt, mscan, mlines;
    bit mdrop;

    tetris_board_engine #(
        .BOARD_W(W), .BOARD_H(H), .PIECE_W(PW),
        .DROP_DIV(DD), .LINE_W(LW)
    ) dut (
        .in_clk       (in_clk),
        .in_restart   (in_restart),
        .in_move      (in_move),
        .board_out    (board_out),
        .out_lines    (out_lines),
        .out_game_over(out_game_over),
        .out_busy     (out_busy)
    );

    always #5 in_clk = ~in_clk;

    task automatic model_reset();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                stk[r][c] = 1'b0;
        pr = 0; pc = 0; mst = M_SPAWN; mcnt = 0;
        mscan = 0; mlines = 0; mdrop = 1'b0;
    endtask

    function automatic bit fits(input int r, input int c);
        for (int i = 0; i < PW; i++)
            if (stk[r][c+i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit row_is_full(input int r);
        for (int c = 0; c < W; c++)
            if (!stk[r][c]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input logic [1:0] mv);
        bit stp;
        case (mst)
            M_SPAWN: begin
                pr = 0;
                pc = (W - PW) / 2;
                if (!fits(0, pc)) mst = M_OVER;
                else begin
                    mst = M_FALL; mcnt = 0; mdrop = 1'b0;
                end
            end
            M_FALL: begin
                stp  = mdrop || (mcnt == DD - 1);
                mcnt = (mcnt == DD - 1) ? 0 : mcnt + 1;
                if (!mdrop && mv == MV_DROP) mdrop = 1'b1;
                else if (!mdrop && !stp) begin
                    if (mv == MV_LEFT && pc > 0 && fits(pr, pc - 1))
                        pc--;
                    else if (mv == MV_RIGHT && pc < W - PW && fits(pr, pc + 1))
                        pc++;
                end
                if (stp) begin
                    if (pr + 1 < H && fits(pr + 1, pc)) pr++;
                    else mst = M_LOCK;
                end
            end
            M_LOCK: begin
                for (int i = 0; i < PW; i++) stk[pr][pc+i] = 1'b1;
                mscan = H - 1;
                mst = M_CLEAR;
            end
            M_CLEAR: begin
                if (row_is_full(mscan)) begin
                    for (int r = mscan; r > 0; r--)
                        for (int c = 0; c < W; c++)
                            stk[r][c] = stk[r-1][c];
                    for (int c = 0; c < W; c++) stk[0][c] = 1'b0;
                    if (mlines < (1 << LW) - 1) mlines++;
                end else if (mscan == 0) mst = M_SPAWN;
                else mscan--;
            end
            default: ;
        endcase
    endtask

    function automatic logic [N-1:0] exp_board();
        logic [N-1:0] b;
        b = '0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                b[r*W+c] = stk[r][c]
                    | (mst == M_FALL && r == pr && c >= pc && c < pc + PW);
        return b;
    endfunction

    task automatic tick(input logic [1:0] mv);
        in_move = mv;
        model_step(mv);
        @(posedge in_clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge in_clk);
        in_restart = 1'b1;
        in_move = MV_NONE;
        model_reset();
        @(negedge in_clk);
        in_restart = 1'b0;
    endtask

    task automatic wait_land(input string tag);
        bit seen, done;
        seen = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick(MV_NONE);
            total++;
            if (board_out !== exp_board()) begin
                bad++;
                $display("FAIL %s_board got %h want %h", tag, board_out, exp_board());
            end
            if (seen && !out_busy) done = 1'b1;
            seen |= out_busy;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_timeout busy never cleared got %0b want 1", tag, done);
        end
    endtask

    task automatic test_reset();
        @(negedge in_clk);
        in_restart = 1'b1;
        in_move = MV_NONE;
        model_reset();
        #2;
        total += 4;
        if (board_out !== '0) begin bad++; $display("FAIL rst_board got %h want 0", board_out); end
        if (out_lines !== '0) begin bad++; $display("FAIL rst_lines got %0d want 0", out_lines); end
        if (out_game_over !== 1'b0) begin bad++; $display("FAIL rst_over got %b want 0", out_game_over); end
        if (out_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", out_busy); end
        @(negedge in_clk);
        in_restart = 1'b0;
        tick(MV_NONE);
        total += 3;
        if (board_out !== 32'h0000_0006) begin bad++; $display("FAIL spawn_board got %h want 00000006", board_out); end
        if (out_lines !== '0) begin bad++; $display("FAIL spawn_lines got %0d want 0", out_lines); end
        if (out_busy !== 1'b0) begin bad++; $display("FAIL spawn_busy got %b want 0", out_busy); end
    endtask

    task automatic test_gravity();
        for (int i = 0; i < DD; i++) begin
            tick(MV_NONE);
            total++;
            if (board_out !== exp_board()) begin
                bad++;
                $display("FAIL grav_model got %h want %h", board_out, exp_board());
            end
        end
        total++;
        if (board_out !== 32'h0000_0060) begin bad++; $display("FAIL grav_board got %h want 00000060", board_out); end
    endtask

    task automatic test_moves();
        logic [1:0] seq [7];
        logic [N-1:0] want [7];
        seq  = '{MV_LEFT, MV_LEFT, MV_LEFT, MV_NONE, MV_RIGHT, MV_RIGHT, MV_RIGHT};
        want = '{32'h3, 32'h3, 32'h3, 32'h30, 32'h60, 32'hC0, 32'hC0};
        apply_reset();
        tick(MV_NONE);
        for (int i = 0; i < 7; i++) begin
            tick(seq[i]);
            total += 2;
            if (board_out !== want[i]) begin
                bad++;
                $display("FAIL move%0d got %h want %h", i, board_out, want[i]);
            end
            if (board_out !== exp_board()) begin
                bad++;
                $display("FAIL move%0d_model got %h want %h", i, board_out, exp_board());
            end
        end
    endtask

    task automatic test_hard_drop();
        apply_reset();
        tick(MV_NONE);
        tick(MV_DROP);
        for (int i = 0; i < H - 1; i++) begin
            tick(MV_LEFT);
            total++;
            if (board_out !== exp_board()) begin
                bad++;
                $display("FAIL drop_row%0d got %h want %h", i, board_out, exp_board());
            end
        end
        total++;
        if (board_out !== 32'h6000_0000) begin bad++; $display("FAIL drop_bottom got %h want 60000000", board_out); end
        tick(MV_NONE);
        total++;
        if (out_busy !== 1'b1) begin bad++; $display("FAIL lock_busy got %b want 1", out_busy); end
        for (int i = 0; i < 1 + H; i++) tick(MV_NONE);
        total++;
        if (out_busy !== 1'b0) begin bad++; $display("FAIL clear_done_busy got %b want 0", out_busy); end
        tick(MV_NONE);
        total++;
        if (board_out !== 32'h6000_0006) begin bad++; $display("FAIL respawn got %h want 60000006", board_out); end
    endtask

    task automatic test_line_clear();
        apply_reset();
        tick(MV_NONE);
        tick(MV_LEFT);
        tick(MV_DROP);
        wait_land("lc1");
        tick(MV_NONE);
        tick(MV_RIGHT);
        tick(MV_DROP);
        wait_land("lc2");
        tick(MV_NONE);
        total += 2;
        if (out_lines !== 8'd1) begin bad++; $display("FAIL lc_lines got %0d want 1", out_lines); end
        if (board_out !== 32'h0000_0006) begin bad++; $display("FAIL lc_board got %h want 00000006", board_out); end
    endtask

    task automatic test_mid_clear_reset();
        apply_reset();
        tick(MV_NONE);
        tick(MV_LEFT);
        tick(MV_DROP);
        wait_land("mc1");
        tick(MV_NONE);
        tick(MV_RIGHT);
        tick(MV_DROP);
        for (int i = 0; i < 60 && !out_busy; i++) tick(MV_NONE);
        tick(MV_NONE);
        tick(MV_NONE);
        @(negedge in_clk);
        in_restart = 1'b1;
        model_reset();
        #1;
        total += 3;
        if (board_out !== '0) begin bad++; $display("FAIL mc_board got %h want 0", board_out); end
        if (out_lines !== '0) begin bad++; $display("FAIL mc_lines got %0d want 0", out_lines); end
        if (out_busy !== 1'b0) begin bad++; $display("FAIL mc_busy got %b want 0", out_busy); end
        @(negedge in_clk);
        in_restart = 1'b0;
        tick(MV_NONE);
        total++;
        if (board_out !== 32'h0000_0006) begin bad++; $display("FAIL mc_spawn got %h want 00000006", board_out); end
    endtask

    task automatic test_game_over();
        apply_reset();
        tick(MV_NONE);
        for (int k = 0; k < H; k++) begin
            tick(MV_DROP);
            wait_land("go");
            tick(MV_NONE);
        end
        total += 3;
        if (out_game_over !== 1'b1) begin bad++; $display("FAIL go_flag got %b want 1", out_game_over); end
        if (board_out !== 32'h6666_6666) begin bad++; $display("FAIL go_board got %h want 66666666", board_out); end
        if (board_out !== exp_board()) begin bad++; $display("FAIL go_model got %h want %h", board_out, exp_board()); end
        tick(MV_LEFT);
        tick(MV_DROP);
        tick(MV_RIGHT);
        total += 2;
        if (board_out !== 32'h6666_6666) begin bad++; $display("FAIL go_frozen got %h want 66666666", board_out); end
        if (out_game_over !== 1'b1) begin bad++; $display("FAIL go_stay got %b want 1", out_game_over); end
        @(negedge in_clk);
        in_restart = 1'b1;
        model_reset();
        #1;
        total += 4;
        if (board_out !== '0) begin bad++; $display("FAIL go_rst_board got %h want 0", board_out); end
        if (out_game_over !== 1'b0) begin bad++; $display("FAIL go_rst_flag got %b want 0", out_game_over); end
        if (out_lines !== '0) begin bad++; $display("FAIL go_rst_lines got %0d want 0", out_lines); end
        if (out_busy !== 1'b0) begin bad++; $display("FAIL go_rst_busy got %b want 0", out_busy); end
        @(negedge in_clk);
        in_restart = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] mv;
        int errs;
        errs = 0;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if (mst == M_OVER || $urandom_range(0, 499) == 0) apply_reset();
            mv = 2'($urandom_range(0, 3));
            if (mv == MV_DROP && $urandom_range(0, 2) != 0) mv = MV_NONE;
            tick(mv);
            total++;
            if (board_out !== exp_board() || out_lines !== LW'(mlines)
                || out_game_over !== (mst == M_OVER)
                || out_busy !== (mst == M_LOCK || mst == M_CLEAR)) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL rand%0d got b=%h l=%0d o=%b y=%b want b=%h l=%0d st=%0d",
                             i, board_out, out_lines, out_game_over, out_busy,
                             exp_board(), mlines, mst);
            end
        end
    endtask

    initial begin
        in_restart = 1'b1;
        in_move = MV_NONE;
        model_reset();
        test_reset();
        test_gravity();
        test_moves();
        test_hard_drop();
        test_line_clear();
        test_mid_clear_reset();
        test_game_over();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
